// File: rtl/tpram_param_bypass_pkg.sv
// Shared constants and helpers for the tpram_param_bypass RAM slice.
// byte_merge is used for both the array write and the read-during-write bypass.
package tpram_pkg;

  localparam int unsigned RDW_OLD     = 0;
  localparam int unsigned RDW_NEW     = 1;
  localparam int unsigned MERGE_MAX_W = 1024;
  localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

  function automatic int unsigned nbytes(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

  // Callers zero-extend into MERGE_MAX_W and truncate the result back to their width.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] be,
    input int unsigned            byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      if (be[MERGE_IDX_W'(i / byte_w)]) res[MERGE_IDX_W'(i)] = new_w[MERGE_IDX_W'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/tpram_param_bypass_if.sv
// Write channel A / read channel B bundle for tpram_param_bypass.
interface tpram_param_bypass_if
  import tpram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned NB = nbytes(DATA_W, BYTE_W);

  logic              wea;
  logic [NB-1:0]     bea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] data_i_a;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] data_o_b;
  logic              valid_o_b;
  logic              err_o_b;
  logic              coll_o;
  logic [CNT_W-1:0]  coll_cnt_o;

  modport master (
    output wea, bea, addra, data_i_a, enb, addrb,
    input  data_o_b, valid_o_b, err_o_b, coll_o, coll_cnt_o
  );

  modport slave (
    input  wea, bea, addra, data_i_a, enb, addrb,
    output data_o_b, valid_o_b, err_o_b, coll_o, coll_cnt_o
  );
endinterface

// File: rtl/tpram_param_bypass_out_stage.sv
// One read-result register slice (valid/err/coll/data); data holds while no read is in flight.
module tpram_out_stage #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic              coll_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              err_o,
  output logic              coll_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q, err_q, coll_q;
  logic              err_d, coll_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    err_d  = valid_i & err_i;
    coll_d = valid_i & coll_i;
    data_d = valid_i ? data_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      coll_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      err_q   <= err_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign coll_o  = coll_q;
  assign data_o  = data_q;
endmodule

// File: rtl/tpram_param_bypass.sv
// Simple dual-port RAM with byte enables, read-during-write bypass and collision counter.
// Define TPRAM_OUTREG_EN for an extra output register (read latency 2 instead of 1).
module tpram_param_bypass
  import tpram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RDW_MODE = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tpram_param_bypass_if.slave  bus
);
  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
    $error("tpram_param_bypass: DATA_W must be a multiple of BYTE_W");
  end
  if ((DEPTH < 1) || (DEPTH > (2**ADDR_W))) begin : g_bad_depth
    $error("tpram_param_bypass: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_in_range, rd_in_range, wr_hit, coll, cnt_inc;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_word, rd_word, rd_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wr_in_range = {1'b0, bus.addra} < DEPTH_C;
    rd_in_range = {1'b0, bus.addrb} < DEPTH_C;
    wr_idx      = IDX_W'(bus.addra);
    rd_idx      = IDX_W'(bus.addrb);
    wr_hit      = bus.wea & wr_in_range & (|bus.bea);
    coll        = wr_hit & bus.enb & (bus.addra == bus.addrb);
    rd_word     = mem_q[rd_idx];
    wr_word     = DATA_W'(byte_merge(MERGE_MAX_W'(mem_q[wr_idx]), MERGE_MAX_W'(bus.data_i_a),
                                     MERGE_MAX_W'(bus.bea), BYTE_W));
    // On a collision wr_idx == rd_idx, so the merged write word is also the bypassed read word.
    if (!rd_in_range)                         rd_data = '0;
    else if (coll && (RDW_MODE == RDW_NEW))   rd_data = wr_word;
    else                                      rd_data = rd_word;
  end

  always_ff @(posedge clk) begin
    if (wr_hit) mem_q[wr_idx] <= wr_word;
  end

  logic              s1_valid, s1_err, s1_coll;
  logic [DATA_W-1:0] s1_data;

  tpram_out_stage #(.DATA_W(DATA_W)) u_stage_rd (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.enb),
    .err_i   (~rd_in_range),
    .coll_i  (coll),
    .data_i  (rd_data),
    .valid_o (s1_valid),
    .err_o   (s1_err),
    .coll_o  (s1_coll),
    .data_o  (s1_data)
  );

`ifdef TPRAM_OUTREG_EN
  tpram_out_stage #(.DATA_W(DATA_W)) u_stage_out (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid),
    .err_i   (s1_err),
    .coll_i  (s1_coll),
    .data_i  (s1_data),
    .valid_o (bus.valid_o_b),
    .err_o   (bus.err_o_b),
    .coll_o  (bus.coll_o),
    .data_o  (bus.data_o_b)
  );
  assign cnt_inc = s1_coll;
`else
  assign bus.valid_o_b = s1_valid;
  assign bus.err_o_b   = s1_err;
  assign bus.coll_o    = s1_coll;
  assign bus.data_o_b  = s1_data;
  assign cnt_inc       = coll;
`endif

  // Counter is fed by the input of the last stage so it moves on the same edge coll_o rises.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.coll_cnt_o = cnt_q;
endmodule
